// File: rtl/avalon_pwm_pkg.sv
// Shared definitions for the multi-channel Avalon PWM: register offsets, CTRL layout, helpers.
// CTRL IE/PEND bits are only live when PWM_IRQ_EN is defined.
package avalon_pwm_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] OFF_WIDTH  = 2'd0;
   localparam logic [1:0] OFF_PERIOD = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;
   localparam logic [1:0] OFF_COUNT  = 2'd3;

   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_POL  = 1;
   localparam int unsigned CTRL_IE   = 2;
   localparam int unsigned CTRL_PEND = 8;

   typedef struct packed {
      logic pend;
      logic ie;
      logic pol;
      logic en;
   } ctrl_t;

   // Byte-lane merge of a bus write into an existing register value.
   function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_v,
                                                  input logic [DATA_W-1:0] new_v,
                                                  input logic [3:0]        be);
      logic [DATA_W-1:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] ctrl_word(input ctrl_t c);
      logic [DATA_W-1:0] w;
      w            = '0;
      w[CTRL_EN]   = c.en;
      w[CTRL_POL]  = c.pol;
      w[CTRL_IE]   = c.ie;
      w[CTRL_PEND] = c.pend;
      return w;
   endfunction

endpackage

// File: rtl/avalon_pwm_multi_channel.sv
// pwm_channel: one PWM channel with pending/active shadow registers, counter and registered output.
// With PWM_IRQ_EN defined the sticky PEND flag is set on every counter wrap.
module pwm_channel
   import avalon_pwm_pkg::*;
#(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned DEF_PERIOD = 500000,
   parameter int unsigned DEF_WIDTH  = 250000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_width_i,
   input  logic             wr_period_i,
   input  logic             wr_ctrl_i,
   input  logic [CNT_W-1:0] wdata_i,
   input  ctrl_t            ctrl_i,
   output logic [CNT_W-1:0] width_o,
   output logic [CNT_W-1:0] period_o,
   output ctrl_t            ctrl_o,
   output logic             pwm_o
);

   logic [CNT_W-1:0] pend_width_q, pend_width_d;
   logic [CNT_W-1:0] pend_period_q, pend_period_d;
   logic [CNT_W-1:0] act_width_q, act_width_d;
   logic [CNT_W-1:0] act_period_q, act_period_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             pwm_q, pwm_d;
   logic             run, wrap, load;

   // A zero active period keeps the counter idle instead of underflowing the wrap compare.
   always_comb begin
      run  = ctrl_q.en && (act_period_q != '0);
      wrap = run && (cnt_q == act_period_q - CNT_W'(1));
      load = wrap || !ctrl_q.en;

      pend_width_d  = wr_width_i  ? wdata_i : pend_width_q;
      pend_period_d = wr_period_i ? wdata_i : pend_period_q;
      // Active regs take the pre-write pending value, so a write on the wrap cycle waits a period.
      act_width_d   = load ? pend_width_q  : act_width_q;
      act_period_d  = load ? pend_period_q : act_period_q;

      cnt_d = (run && !wrap) ? cnt_q + CNT_W'(1) : '0;
      pwm_d = (run && (cnt_q < act_width_q)) ^ ctrl_q.pol;

      ctrl_d = wr_ctrl_i ? ctrl_i : ctrl_q;
`ifdef PWM_IRQ_EN
      if (wrap) ctrl_d.pend = 1'b1;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_width_q  <= CNT_W'(DEF_WIDTH);
         pend_period_q <= CNT_W'(DEF_PERIOD);
         act_width_q   <= CNT_W'(DEF_WIDTH);
         act_period_q  <= CNT_W'(DEF_PERIOD);
         cnt_q         <= '0;
         ctrl_q        <= '0;
         pwm_q         <= 1'b0;
      end else begin
         pend_width_q  <= pend_width_d;
         pend_period_q <= pend_period_d;
         act_width_q   <= act_width_d;
         act_period_q  <= act_period_d;
         cnt_q         <= cnt_d;
         ctrl_q        <= ctrl_d;
         pwm_q         <= pwm_d;
      end
   end

   assign width_o  = pend_width_q;
   assign period_o = pend_period_q;
   assign ctrl_o   = ctrl_q;
   assign pwm_o    = pwm_q;

endmodule

// File: rtl/avalon_pwm_multi.sv
// N-channel PWM behind one Avalon-MM slave: address decode, byte-lane merge, registered read path.
// Define PWM_IRQ_EN to add the ins_irq output and the CTRL IE/PEND bits.
module avalon_pwm_multi
   import avalon_pwm_pkg::*;
#(
   parameter  int unsigned N_CH       = 4,
   parameter  int unsigned CNT_W      = 32,
   parameter  int unsigned DEF_PERIOD = 500000,
   parameter  int unsigned DEF_WIDTH  = 250000,
   localparam int unsigned ADDR_W     = $clog2(N_CH) + 2
) (
   input  logic              csi_clk,
   input  logic              rsi_rst,
   input  logic              avs_s0_chipselect,
   input  logic              avs_s0_read,
   input  logic              avs_s0_write,
   input  logic [ADDR_W-1:0] avs_s0_address,
   input  logic [3:0]        avs_s0_byteenable,
   input  logic [31:0]       avs_s0_writedata,
   output logic [31:0]       avs_s0_readdata,
   output logic [N_CH-1:0]   coe_pwm_out
`ifdef PWM_IRQ_EN
   ,
   output logic              ins_irq
`endif
);

   localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [CH_W-1:0]   ch_idx;
   logic [1:0]        offset;
   logic              wr_en, rd_en;
   logic [CNT_W-1:0]  ch_width  [N_CH];
   logic [CNT_W-1:0]  ch_period [N_CH];
   ctrl_t             ch_ctrl   [N_CH];
   logic [DATA_W-1:0] ch_rdata  [N_CH];
   logic [DATA_W-1:0] rd_mux;

   if (ADDR_W > 2) begin : g_idx
      assign ch_idx = avs_s0_address[ADDR_W-1:2];
   end else begin : g_idx_single
      assign ch_idx = '0;
   end

   assign offset = avs_s0_address[1:0];
   assign wr_en  = avs_s0_chipselect && avs_s0_write;
   assign rd_en  = avs_s0_chipselect && avs_s0_read;

`ifdef PWM_IRQ_EN
   logic [N_CH-1:0] irq_vec;
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic              sel;
      logic [CNT_W-1:0]  old_v;
      logic [CNT_W-1:0]  wdata;
      ctrl_t             ctrl_new;
      logic [DATA_W-1:0] rdata;

      assign sel   = wr_en && (ch_idx == CH_W'(i));
      assign old_v = (offset == OFF_PERIOD) ? ch_period[i] : ch_width[i];
      assign wdata = CNT_W'(be_merge(DATA_W'(old_v), avs_s0_writedata, avs_s0_byteenable));

      // PEND is write-1-to-clear through byte lane 1; other CTRL bits come from lane 0.
      always_comb begin
         ctrl_new = ch_ctrl[i];
         if (avs_s0_byteenable[0]) begin
            ctrl_new.en  = avs_s0_writedata[CTRL_EN];
            ctrl_new.pol = avs_s0_writedata[CTRL_POL];
`ifdef PWM_IRQ_EN
            ctrl_new.ie  = avs_s0_writedata[CTRL_IE];
`endif
         end
`ifdef PWM_IRQ_EN
         if (avs_s0_byteenable[1] && avs_s0_writedata[CTRL_PEND]) ctrl_new.pend = 1'b0;
`endif
      end

      // COUNT is write-ignored and reads as zero.
      always_comb begin
         unique case (offset)
            OFF_WIDTH:  rdata = DATA_W'(ch_width[i]);
            OFF_PERIOD: rdata = DATA_W'(ch_period[i]);
            OFF_CTRL:   rdata = ctrl_word(ch_ctrl[i]);
            OFF_COUNT:  rdata = '0;
            default:    rdata = '0;
         endcase
      end
      assign ch_rdata[i] = rdata;

      pwm_channel #(
         .CNT_W      (CNT_W),
         .DEF_PERIOD (DEF_PERIOD),
         .DEF_WIDTH  (DEF_WIDTH)
      ) u_ch (
         .clk_i       (csi_clk),
         .rst_i       (rsi_rst),
         .wr_width_i  (sel && (offset == OFF_WIDTH)),
         .wr_period_i (sel && (offset == OFF_PERIOD)),
         .wr_ctrl_i   (sel && (offset == OFF_CTRL)),
         .wdata_i     (wdata),
         .ctrl_i      (ctrl_new),
         .width_o     (ch_width[i]),
         .period_o    (ch_period[i]),
         .ctrl_o      (ch_ctrl[i]),
         .pwm_o       (coe_pwm_out[i])
      );

`ifdef PWM_IRQ_EN
      assign irq_vec[i] = ch_ctrl[i].pend && ch_ctrl[i].ie;
`endif
   end

   // Unmatched channel indices fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (ch_idx == CH_W'(i)) rd_mux = ch_rdata[i];
      end
   end

   always_ff @(posedge csi_clk) begin
      if (rsi_rst) begin
         avs_s0_readdata <= '0;
      end else if (rd_en) begin
         avs_s0_readdata <= rd_mux;
      end
   end

`ifdef PWM_IRQ_EN
   always_ff @(posedge csi_clk) begin
      if (rsi_rst) ins_irq <= 1'b0;
      else         ins_irq <= |irq_vec;
   end
`endif

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// Scoreboard bench for avalon_pwm_multi (3 channels, so channel index 3 is out of range).
// Honours PWM_IRQ_EN when compiled with it.
module tb_avalon_pwm_multi;

   localparam int          N    = 3;
   localparam longint      DEFP = 500000;
   localparam longint      DEFW = 250000;

   logic        csi_clk = 1'b0;
   logic        rsi_rst = 1'b1;
   logic        avs_s0_chipselect = 1'b0;
   logic        avs_s0_read = 1'b0;
   logic        avs_s0_write = 1'b0;
   logic [3:0]  avs_s0_address = '0;
   logic [3:0]  avs_s0_byteenable = '0;
   logic [31:0] avs_s0_writedata = '0;
   logic [31:0] avs_s0_readdata;
   logic [N-1:0] coe_pwm_out;
`ifdef PWM_IRQ_EN
   logic        ins_irq;
`endif

   always #5 csi_clk = ~csi_clk;

   avalon_pwm_multi #(
      .N_CH(N), .CNT_W(32), .DEF_PERIOD(500000), .DEF_WIDTH(250000)
   ) dut (
      .csi_clk           (csi_clk),
      .rsi_rst           (rsi_rst),
      .avs_s0_chipselect (avs_s0_chipselect),
      .avs_s0_read       (avs_s0_read),
      .avs_s0_write      (avs_s0_write),
      .avs_s0_address    (avs_s0_address),
      .avs_s0_byteenable (avs_s0_byteenable),
      .avs_s0_writedata  (avs_s0_writedata),
      .avs_s0_readdata   (avs_s0_readdata),
      .coe_pwm_out       (coe_pwm_out)
`ifdef PWM_IRQ_EN
      ,
      .ins_irq           (ins_irq)
`endif
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference model state: pending/active settings, position within the period, flags.
   longint   m_pw[N], m_pp[N], m_aw[N], m_ap[N], m_cnt[N];
   bit       m_en[N], m_pol[N], m_ie[N], m_pend[N];
   bit [N-1:0] m_out;
   bit [31:0]  m_rd;
   bit         m_irq;

   typedef struct {
      bit [N-1:0] pwm;
      bit [31:0]  rd;
      bit         irq;
   } exp_t;
   exp_t exp_q[$];

   function automatic bit [31:0] lane_merge(bit [31:0] old_v, bit [31:0] wd, bit [3:0] be);
      bit [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old_v & ~mask) | (wd & mask);
   endfunction

   function automatic bit [31:0] m_read(bit [3:0] a);
      int ch, off;
      ch  = int'(a) / 4;
      off = int'(a) % 4;
      if (ch >= N) return 32'h0;
      case (off)
         0: return 32'(m_pw[ch]);
         1: return 32'(m_pp[ch]);
         2: return 32'(m_en[ch]) | (32'(m_pol[ch]) << 1) | (32'(m_ie[ch]) << 2) | (32'(m_pend[ch]) << 8);
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge csi_clk) begin : model
      exp_t e;
      bit   running, period_end, any_irq;
      int   wch, woff;
      if (rsi_rst) begin
         for (int c = 0; c < N; c++) begin
            m_pw[c] = DEFW; m_pp[c] = DEFP; m_aw[c] = DEFW; m_ap[c] = DEFP; m_cnt[c] = 0;
            m_en[c] = 0; m_pol[c] = 0; m_ie[c] = 0; m_pend[c] = 0;
         end
         m_out = '0; m_rd = '0; m_irq = 0;
      end else begin
         if (avs_s0_chipselect && avs_s0_read) m_rd = m_read(avs_s0_address);
         any_irq = 0;
         for (int c = 0; c < N; c++) any_irq |= m_pend[c] & m_ie[c];
         m_irq = any_irq;
         wch  = int'(avs_s0_address) / 4;
         woff = int'(avs_s0_address) % 4;
         for (int c = 0; c < N; c++) begin
            running    = m_en[c] && (m_ap[c] != 0);
            period_end = running && (m_cnt[c] == m_ap[c] - 1);
            m_out[c]   = (running && (m_cnt[c] < m_aw[c])) ^ m_pol[c];
            if (period_end || !m_en[c]) begin
               m_aw[c] = m_pw[c];
               m_ap[c] = m_pp[c];
            end
            m_cnt[c] = (running && !period_end) ? m_cnt[c] + 1 : 0;
            if (avs_s0_chipselect && avs_s0_write && wch == c) begin
               if (woff == 0) m_pw[c] = longint'(lane_merge(32'(m_pw[c]), avs_s0_writedata, avs_s0_byteenable));
               if (woff == 1) m_pp[c] = longint'(lane_merge(32'(m_pp[c]), avs_s0_writedata, avs_s0_byteenable));
               if (woff == 2) begin
                  if (avs_s0_byteenable[0]) begin
                     m_en[c]  = avs_s0_writedata[0];
                     m_pol[c] = avs_s0_writedata[1];
`ifdef PWM_IRQ_EN
                     m_ie[c]  = avs_s0_writedata[2];
`endif
                  end
`ifdef PWM_IRQ_EN
                  if (avs_s0_byteenable[1] && avs_s0_writedata[8]) m_pend[c] = 0;
`endif
               end
            end
`ifdef PWM_IRQ_EN
            if (period_end) m_pend[c] = 1;
`endif
         end
      end
      e.pwm = m_out; e.rd = m_rd; e.irq = m_irq;
      exp_q.push_back(e);
   end

   always @(posedge csi_clk) begin : monitor
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (coe_pwm_out !== e.pwm) begin
            n_err++;
            $display("FAIL pwm_out t=%0t got %b expected %b", $time, coe_pwm_out, e.pwm);
         end
         n_chk++;
         if (avs_s0_readdata !== e.rd) begin
            n_err++;
            $display("FAIL readdata t=%0t got %h expected %h", $time, avs_s0_readdata, e.rd);
         end
`ifdef PWM_IRQ_EN
         n_chk++;
         if (ins_irq !== e.irq) begin
            n_err++;
            $display("FAIL ins_irq t=%0t got %b expected %b", $time, ins_irq, e.irq);
         end
`endif
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
      end
   endtask

   task automatic bus_wr(input int ch, input int off, input logic [31:0] d, input logic [3:0] be);
      avs_s0_address    = 4'(ch * 4 + off);
      avs_s0_byteenable = be;
      avs_s0_writedata  = d;
      avs_s0_chipselect = 1'b1;
      avs_s0_write      = 1'b1;
      @(negedge csi_clk);
      avs_s0_chipselect = 1'b0;
      avs_s0_write      = 1'b0;
   endtask

   task automatic bus_rd(input int ch, input int off);
      avs_s0_address    = 4'(ch * 4 + off);
      avs_s0_chipselect = 1'b1;
      avs_s0_read       = 1'b1;
      @(negedge csi_clk);
      avs_s0_chipselect = 1'b0;
      avs_s0_read       = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge csi_clk);
   endtask

   task automatic count_high(input int ch, input int cycles, output int h);
      h = 0;
      repeat (cycles) begin
         if (coe_pwm_out[ch]) h++;
         @(negedge csi_clk);
      end
   endtask

   task automatic wait_cnt(input int ch, input longint v);
      int k;
      for (k = 0; k < 100; k++) begin
         if (m_cnt[ch] == v) break;
         @(negedge csi_clk);
      end
      if (k == 100) begin
         n_chk++;
         n_err++;
         $display("FAIL wait_cnt ch%0d never reached %0d", ch, v);
      end
   endtask

   initial begin : stim
      int h;
      int r, ch, off;
      logic [31:0] d;
      logic [3:0]  be;

      repeat (3) @(negedge csi_clk);
      rsi_rst = 1'b0;

      // Reset values through the read path
      bus_rd(0, 0); check("rst_width", avs_s0_readdata, 32'd250000);
      bus_rd(2, 1); check("rst_period", avs_s0_readdata, 32'd500000);
      bus_rd(0, 2); check("rst_ctrl", avs_s0_readdata, 32'd0);

      // Byte-lane write into ch1 PERIOD
      bus_wr(1, 1, 32'h0000AB00, 4'b0010);
      bus_rd(1, 1); check("be_merge", avs_s0_readdata, 32'h0007AB20);

      // Basic 3/10 waveform
      bus_wr(0, 0, 32'd3, 4'hF);
      bus_wr(0, 1, 32'd10, 4'hF);
      bus_wr(0, 2, 32'd1, 4'hF);
      idle(2);
      count_high(0, 20, h); check("duty_3_10", 32'(h), 32'd6);

      // Mid-period width change, then a change landing exactly on the wrap cycle
      wait_cnt(0, 5);
      bus_wr(0, 0, 32'd7, 4'hF);
      idle(12);
      wait_cnt(0, 9);
      bus_wr(0, 0, 32'd2, 4'hF);
      idle(30);

      // Boundaries: period 0, width == period, inverted polarity with width 0
      bus_wr(0, 2, 32'd0, 4'hF);
      bus_wr(0, 0, 32'd5, 4'hF);
      bus_wr(0, 1, 32'd0, 4'hF);
      bus_wr(0, 2, 32'd1, 4'hF);
      idle(3);
      count_high(0, 10, h); check("period_zero", 32'(h), 32'd0);
      bus_wr(0, 2, 32'd0, 4'hF);
      bus_wr(0, 0, 32'd10, 4'hF);
      bus_wr(0, 1, 32'd10, 4'hF);
      bus_wr(0, 2, 32'd1, 4'hF);
      idle(3);
      count_high(0, 20, h); check("width_eq_period", 32'(h), 32'd20);
      bus_wr(0, 2, 32'd0, 4'hF);
      bus_wr(0, 0, 32'd0, 4'hF);
      bus_wr(0, 2, 32'd3, 4'hF);
      idle(3);
      count_high(0, 10, h); check("pol_width_zero", 32'(h), 32'd10);

      // Out-of-range channel and COUNT writes are ignored; reads give 0
      bus_wr(3, 0, 32'h55, 4'hF);
      bus_rd(3, 0); check("bad_channel", avs_s0_readdata, 32'd0);
      bus_wr(0, 3, 32'h77, 4'hF);
      bus_rd(0, 3); check("count_read", avs_s0_readdata, 32'd0);

      // Synchronous reset while channels run
      bus_wr(1, 0, 32'd2, 4'hF);
      bus_wr(1, 1, 32'd5, 4'hF);
      bus_wr(1, 2, 32'd1, 4'hF);
      bus_wr(2, 0, 32'd1, 4'hF);
      bus_wr(2, 1, 32'd3, 4'hF);
      bus_wr(2, 2, 32'd3, 4'hF);
      bus_rd(2, 2);
      idle(7);
      rsi_rst = 1'b1;
      @(negedge csi_clk);
      rsi_rst = 1'b0;
      check("rst_pwm", 32'(coe_pwm_out), 32'd0);
      check("rst_readdata", avs_s0_readdata, 32'd0);
      bus_rd(1, 1); check("rst_period_ch1", avs_s0_readdata, 32'd500000);

`ifdef PWM_IRQ_EN
      bus_wr(0, 0, 32'd2, 4'hF);
      bus_wr(0, 1, 32'd4, 4'hF);
      bus_wr(0, 2, 32'h5, 4'hF);
      idle(8);
      check("irq_set", 32'(ins_irq), 32'd1);
      bus_wr(0, 2, 32'h105, 4'hF);
      idle(8);
      check("irq_reassert", 32'(ins_irq), 32'd1);
      bus_wr(0, 2, 32'h0, 4'hF);
`endif

      // Randomised traffic against the model
      for (int it = 0; it < 500; it++) begin
         r   = $urandom_range(0, 9);
         ch  = $urandom_range(0, 3);
         off = $urandom_range(0, 3);
         be  = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0)  d = $urandom;
         else if (off < 2)                d = 32'($urandom_range(0, 12));
         else                             d = $urandom & 32'h0000_0107;
         if (r < 5) begin
            bus_wr(ch, off, d, be);
         end else if (r < 8) begin
            bus_rd(ch, off);
         end else if (r == 8) begin
            idle($urandom_range(1, 8));
         end else if ($urandom_range(0, 19) == 0) begin
            rsi_rst = 1'b1;
            @(negedge csi_clk);
            rsi_rst = 1'b0;
         end else begin
            idle(1);
         end
      end

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
